// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: control vector + payload across a stage boundary
// with valid/ready handshake, synchronous flush and an optional two-entry skid buffer.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic              inFire;
    logic              outFire;
    logic              headValid;
    logic              readyRaw;
    logic [CTRL_W-1:0] headCtrl;
    logic [DATA_W-1:0] headData;

    assign inFire    = in_valid & in_ready;
    assign outFire   = headValid & out_ready;
    // Reset forces ready high so upstream never sees a stale stall during reset.
    assign in_ready  = readyRaw | rst;
    assign out_valid = headValid;
    assign out_ctrl  = headValid ? headCtrl : '0;
    assign out_data  = headData;

    generate
        if (SKID != 0) begin : gSkid
            state_t            state;
            state_t            stateNext;
            logic              rdyQ;
            logic [CTRL_W-1:0] skidCtrl;
            logic [DATA_W-1:0] skidData;

            always_comb begin
                stateNext = state;
                if (flush) begin
                    stateNext = EMPTY;
                end else begin
                    case (state)
                        EMPTY:   if (inFire) stateNext = ONE;
                        ONE:     if (inFire && !outFire) stateNext = FULL;
                                 else if (!inFire && outFire) stateNext = EMPTY;
                        FULL:    if (outFire) stateNext = ONE;
                        default: stateNext = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= EMPTY;
                    rdyQ     <= 1'b1;
                    headCtrl <= '0;
                    headData <= '0;
                    skidCtrl <= '0;
                    skidData <= '0;
                end else begin
                    state <= stateNext;
                    // Registered ready: looks only at the next state, never at out_ready directly.
                    rdyQ  <= (stateNext != FULL);
                    if (!flush) begin
                        case (state)
                            EMPTY: begin
                                if (inFire) begin
                                    headCtrl <= in_ctrl;
                                    headData <= in_data;
                                end
                            end
                            ONE: begin
                                if (inFire && outFire) begin
                                    headCtrl <= in_ctrl;
                                    headData <= in_data;
                                end else if (inFire) begin
                                    skidCtrl <= in_ctrl;
                                    skidData <= in_data;
                                end
                            end
                            FULL: begin
                                if (outFire) begin
                                    headCtrl <= skidCtrl;
                                    headData <= skidData;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            assign headValid = (state != EMPTY);
            assign readyRaw  = rdyQ;
            assign count     = state;
        end else begin : gPlain
            logic validQ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    validQ   <= 1'b0;
                    headCtrl <= '0;
                    headData <= '0;
                end else if (flush) begin
                    validQ <= 1'b0;
                end else if (inFire) begin
                    validQ   <= 1'b1;
                    headCtrl <= in_ctrl;
                    headData <= in_data;
                end else if (outFire) begin
                    validQ <= 1'b0;
                end
            end

            assign headValid = validQ;
            assign readyRaw  = ~validQ | out_ready;
            assign count     = {1'b0, validQ};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and checks both against
// queue-based reference models of an in-order elastic stage.
module tb_pipe_stage_reg;
    localparam int CW = 8;
    localparam int DW = 128;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, inValid, outReady, flush;
    logic [CW-1:0] inCtrl;
    logic [DW-1:0] inData;

    logic          s1InReady, s1OutValid;
    logic [CW-1:0] s1OutCtrl;
    logic [DW-1:0] s1OutData;
    logic [1:0]    s1Count;
    logic          s0InReady, s0OutValid;
    logic [CW-1:0] s0OutCtrl;
    logic [DW-1:0] s0OutData;
    logic [1:0]    s0Count;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dutSkid (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(s1InReady),
        .in_ctrl(inCtrl), .in_data(inData), .flush(flush),
        .out_valid(s1OutValid), .out_ready(outReady), .out_ctrl(s1OutCtrl),
        .out_data(s1OutData), .count(s1Count)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dutPlain (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(s0InReady),
        .in_ctrl(inCtrl), .in_data(inData), .flush(flush),
        .out_valid(s0OutValid), .out_ready(outReady), .out_ctrl(s0OutCtrl),
        .out_data(s0OutData), .count(s0Count)
    );

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;
    bit            rdy1 = 1'b1;
    bit            chkEn = 1'b0;
    bit            fire1;
    int            errs = 0;
    int            checks = 0;
    int            nextVal;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cyc(input bit r, input bit iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input bit ordy, input bit fl);
        bit e1, e0, f1, f0, o1, o0;
        @(negedge clk);
        rst = r; inValid = iv; inCtrl = ic; inData = id; outReady = ordy; flush = fl;
        #1;
        e1 = r | rdy1;
        e0 = r | (q0.size() == 0) | ordy;
        if (chkEn) begin
            chk("s1.in_ready",  s1InReady,  e1);
            chk("s1.out_valid", s1OutValid, q1.size() != 0);
            chk("s1.out_ctrl",  s1OutCtrl,  q1.size() != 0 ? q1[0].c : '0);
            chk("s1.out_data",  s1OutData,  q1.size() != 0 ? q1[0].d : last1);
            chk("s1.count",     s1Count,    q1.size());
            chk("s0.in_ready",  s0InReady,  e0);
            chk("s0.out_valid", s0OutValid, q0.size() != 0);
            chk("s0.out_ctrl",  s0OutCtrl,  q0.size() != 0 ? q0[0].c : '0);
            chk("s0.out_data",  s0OutData,  q0.size() != 0 ? q0[0].d : last0);
            chk("s0.count",     s0Count,    q0.size());
        end
        f1 = iv & e1;
        f0 = iv & e0;
        o1 = (q1.size() != 0) & ordy;
        o0 = (q0.size() != 0) & ordy;
        fire1 = f1 & ~r & ~fl;
        @(posedge clk);
        if (r) begin
            q1.delete(); q0.delete();
            last1 = '0; last0 = '0;
        end else if (fl) begin
            q1.delete(); q0.delete();
        end else begin
            if (o1) void'(q1.pop_front());
            if (f1) q1.push_back('{c: ic, d: id});
            if (o0) void'(q0.pop_front());
            if (f0) q0.push_back('{c: ic, d: id});
        end
        if (q1.size() != 0) last1 = q1[0].d;
        if (q0.size() != 0) last0 = q0[0].d;
        rdy1 = (q1.size() < 2);
    endtask

    initial begin
        // Reset for two cycles with an upstream entry offered; first cycle precedes reset.
        cyc(1, 1, 8'hA5, 128'd77, 1, 0);
        chkEn = 1'b1;
        cyc(1, 1, 8'hA5, 128'd78, 1, 0);
        cyc(0, 0, 8'h00, 128'd0, 1, 0);
        cyc(0, 0, 8'h00, 128'd0, 1, 0);

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) cyc(0, 1, 8'hA5, DW'(i), 1, 0);
        cyc(0, 0, 8'h5A, 128'd0, 1, 0);
        cyc(0, 0, 8'h5A, 128'd0, 1, 0);

        // Backpressure: out_ready low for four cycles starting at cycle 3
        nextVal = 1;
        for (int t = 0; t < 16; t++) begin
            cyc(0, nextVal <= 6, 8'h3C, DW'(nextVal), !(t >= 3 && t < 7), 0);
            if (fire1) nextVal++;
        end

        // Fill to FULL, then flush with in and out both offered
        cyc(0, 1, 8'h11, 128'd100, 0, 0);
        cyc(0, 1, 8'h12, 128'd101, 0, 0);
        cyc(0, 1, 8'h13, 128'd102, 1, 1);
        cyc(0, 0, 8'h14, 128'd103, 1, 0);
        // Flush in ONE with simultaneous in fire and out fire
        cyc(0, 1, 8'h15, 128'd104, 1, 0);
        cyc(0, 1, 8'h16, 128'd105, 1, 1);
        cyc(0, 0, 8'h17, 128'd106, 1, 0);
        cyc(0, 0, 8'h17, 128'd106, 1, 0);

        // Bubbles between entries carrying all-ones control
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 8'hFF, DW'(200 + k), 1, 0);
            repeat (3) cyc(0, 0, 8'hFF, 128'd999, 1, 0);
        end

        // Toggling out_ready with in_valid held high
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h0F, DW'(300 + i), (i % 2) == 0, 0);
        cyc(0, 0, 8'h00, 128'd0, 1, 0);
        cyc(0, 0, 8'h00, 128'd0, 1, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        cyc(0, 0, 8'h00, 128'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
